// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out streamer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter is sized so it can represent WIDTH+1 bit positions, which covers the parity bit.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter with synchronous clear, count enable and a terminal-count flag.
module piso_bit_cnt #(
  parameter int            CW   = 4,
  parameter logic [CW-1:0] TERM = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out streamer with valid/ready load and strobed shifting.
// Define PISO_STREAM_PARITY_EN to append an even-parity bit after the data bits.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] TERM = CW'(NBITS - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             tc;
  logic             in_shift;
  logic             accept;
  logic             frame_end;
  logic             step;
  logic             data_bit;

  assign in_shift  = (state == SHIFT);
  assign last      = in_shift & tc;
  assign in_ready  = (state == IDLE) | (in_shift & shift_en & last);
  assign accept    = in_valid & in_ready;
  assign frame_end = in_shift & shift_en & last;
  assign step      = in_shift & shift_en & ~last;

  assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  assign data_bit   = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  // Counter restarts on every load and at frame end so IDLE always sees zero.
  piso_bit_cnt #(
    .CW   (CW),
    .TERM (TERM)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept | frame_end),
    .en  (step),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= in_data;
    end else if (frame_end) begin
      state <= IDLE;
    end else if (step) begin
      shreg <= shreg_next;
    end
  end

`ifdef PISO_STREAM_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^in_data;
    end
  end

  // The final frame position carries the captured parity instead of shifted data.
  assign out = in_shift & (last ? par_bit : data_bit);
`else
  assign out = in_shift & data_bit;
`endif

  assign out_valid = in_shift;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: MSB-first and LSB-first instances against a bit-queue reference model.
module tb_piso_stream;
  localparam int W = 8;
`ifdef PISO_STREAM_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         shift_en = 1'b0;

  logic rdy0, o0, ov0, l0;
  logic rdy1, o1, ov1, l1;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .shift_en(shift_en), .out(o0), .out_valid(ov0), .last(l0)
  );

  piso_stream #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .shift_en(shift_en), .out(o1), .out_valid(ov1), .last(l1)
  );

  int   checks = 0;
  int   passes = 0;
  bit   q0[$];
  bit   q1[$];
  bit   rec_on = 1'b0;
  logic [15:0] rec0, rec1;
  int   nrec0, nrec1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Frame as an ordered list of bits: data bits in transmission order, then optional parity.
  task automatic push_frame(input logic [W-1:0] d, input bit lsb, output bit f[$]);
    f = {};
    for (int i = 0; i < W; i++) f.push_back(lsb ? d[i] : d[W-1-i]);
    if (NB > W) f.push_back(^d);
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [W-1:0] d, input logic se,
                     input bit ck = 1'b1);
    bit acc0, acc1;
    bit f[$];
    rst = r; in_valid = iv; in_data = d; shift_en = se;
    @(negedge clk);
    if (ck) begin
      chk("msb_out",   16'(o0),   16'(q0.size() > 0 ? q0[0] : 1'b0));
      chk("msb_valid", 16'(ov0),  16'(q0.size() > 0));
      chk("msb_last",  16'(l0),   16'(q0.size() == 1));
      chk("msb_ready", 16'(rdy0), 16'(q0.size() == 0 || (se && q0.size() == 1)));
      chk("lsb_out",   16'(o1),   16'(q1.size() > 0 ? q1[0] : 1'b0));
      chk("lsb_valid", 16'(ov1),  16'(q1.size() > 0));
      chk("lsb_last",  16'(l1),   16'(q1.size() == 1));
      chk("lsb_ready", 16'(rdy1), 16'(q1.size() == 0 || (se && q1.size() == 1)));
    end
    if (rec_on) begin
      if (ov0 === 1'b1) begin rec0 = {rec0[14:0], o0}; nrec0++; end
      if (ov1 === 1'b1) begin rec1 = {rec1[14:0], o1}; nrec1++; end
    end
    @(posedge clk);
    if (r) begin
      q0.delete(); q1.delete();
    end else begin
      acc0 = iv && (q0.size() == 0 || (se && q0.size() == 1));
      acc1 = iv && (q1.size() == 0 || (se && q1.size() == 1));
      if (se && q0.size() > 0) void'(q0.pop_front());
      if (se && q1.size() > 0) void'(q1.pop_front());
      if (acc0) begin push_frame(d, 1'b0, f); q0 = f; end
      if (acc1) begin push_frame(d, 1'b1, f); q1 = f; end
    end
    #1;
  endtask

  logic [15:0] exp_msb, exp_lsb;

  initial begin
    // Reset: first edge unchecked (outputs still unknown), then reset state checked.
    cyc(1, 0, 8'h00, 0, 1'b0);
    cyc(1, 1, 8'hA5, 1);
    cyc(0, 0, 8'h00, 1);

    // 0xC1 with shift_en held high; record the emitted sequences.
    rec_on = 1'b1; rec0 = '0; rec1 = '0; nrec0 = 0; nrec1 = 0;
    cyc(0, 1, 8'hC1, 1);
    for (int i = 0; i < NB; i++) cyc(0, 0, 8'h00, 1);
    rec_on = 1'b0;
    cyc(0, 0, 8'h00, 1);
`ifdef PISO_STREAM_PARITY_EN
    exp_msb = 16'b110000011;
    exp_lsb = 16'b100000111;
`else
    exp_msb = 16'b11000001;
    exp_lsb = 16'b10000011;
`endif
    chk("msb_c1_seq", rec0, exp_msb);
    chk("lsb_c1_seq", rec1, exp_lsb);
    chk("msb_c1_len", 16'(nrec0), 16'(NB));
    chk("lsb_c1_len", 16'(nrec1), 16'(NB));

    // Back-to-back 0xC1 then 0x0F with in_valid held: no gap between frames.
    rec_on = 1'b1; rec0 = '0; nrec0 = 0; nrec1 = 0;
    cyc(0, 1, 8'hC1, 1);
    for (int i = 0; i < NB; i++) cyc(0, 1, 8'h0F, 1);
    for (int i = 0; i < NB; i++) cyc(0, 0, 8'h00, 1);
    rec_on = 1'b0;
    chk("b2b_len", 16'(nrec0), 16'(2 * NB));
    cyc(0, 0, 8'h00, 1);

    // Stall after bit 3 for three cycles.
    cyc(0, 1, 8'hC1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, 0);
      chk("stall_hold", 16'(o0), 16'h0);
    end
    for (int i = 0; i < NB; i++) cyc(0, 0, 8'h00, 1);

    // Reset mid-frame after bit 4, then a fresh 0x0F frame.
    cyc(0, 1, 8'hC1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'h3C, 1);
    cyc(0, 0, 8'h00, 1);
    rec_on = 1'b1; rec0 = '0; nrec0 = 0; nrec1 = 0;
    cyc(0, 1, 8'h0F, 1);
    for (int i = 0; i < NB; i++) cyc(0, 0, 8'h00, 1);
    rec_on = 1'b0;
`ifdef PISO_STREAM_PARITY_EN
    chk("post_rst_0f", rec0, 16'b000011110);
`else
    chk("post_rst_0f", rec0, 16'b00001111);
`endif

    // Randomized traffic with occasional resets and stalls.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
          W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
